// File: rtl/serial_word_adder_pkg.sv
// Shared constants and state encoding for the multi-word serial adder.
package serial_word_adder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/serial_word_adder_if.sv
// Operand-in / result-out stream bundle for serial_word_adder.
interface serial_word_adder_if #(
    parameter int CNT_W = 3
);
    import serial_word_adder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   in_a;
    logic [WORD_W-1:0]   in_b;
    logic                in_cin;
    logic                in_first;
    logic                in_last;

    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_sum;
    logic [CNT_W-1:0]    out_idx;
    logic                out_last;
    logic                out_cout;
    logic                out_ovf;
    logic                seq_err;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, seq_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, seq_err
    );

endinterface

// File: rtl/ripple_carry_adder.sv
// Purely combinational ripple-carry adder, one full-adder cell per bit.
module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_word_adder.sv
// Multi-precision adder: streams LS-first word pairs through one 32-bit adder,
// chaining carry through a register and flagging final carry/overflow.
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_word_adder_if.slave        bus
);

    state_t            state;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              first_eff;
    logic              len_ovf;
    logic              last_eff;
    logic              proto_err;
    logic              cin_eff;
    logic [CNT_W-1:0]  idx_p0;
    logic [WORD_W-1:0] sum_p0;
    logic              cout_p0;
    logic              ovf_p0;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A word arriving in IDLE always starts an operation, flagged or not.
    assign first_eff = bus.in_first || (state == IDLE);
    assign len_ovf   = (state == ACTIVE) && !bus.in_first && !bus.in_last
                       && (cnt_q == {CNT_W{1'b1}});
    assign last_eff  = bus.in_last || len_ovf;
    assign proto_err = ((state == IDLE) && !bus.in_first)
                       || ((state == ACTIVE) && bus.in_first)
                       || len_ovf;
    assign cin_eff   = first_eff ? bus.in_cin : carry_q;
    assign idx_p0    = first_eff ? '0 : cnt_q;
    assign ovf_p0    = (bus.in_a[WORD_W-1] == bus.in_b[WORD_W-1])
                       && (sum_p0[WORD_W-1] != bus.in_a[WORD_W-1]);

    ripple_carry_adder #(
        .WIDTH (WORD_W)
    ) u_adder (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (cin_eff),
        .sum  (sum_p0),
        .cout (cout_p0)
    );

    // Stage p0 -> output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.seq_err   <= 1'b0;
        end else begin
            bus.seq_err <= accept && proto_err;
            if (accept) begin
                state         <= last_eff ? IDLE : ACTIVE;
                carry_q       <= cout_p0;
                cnt_q         <= idx_p0 + CNT_W'(1);
                bus.out_valid <= 1'b1;
                bus.out_sum   <= sum_p0;
                bus.out_idx   <= idx_p0;
                bus.out_last  <= last_eff;
                bus.out_cout  <= last_eff && cout_p0;
                bus.out_ovf   <= last_eff && ovf_p0;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed vector bench for serial_word_adder: table-driven streaming plus
// backpressure, protocol-error and mid-operation reset sequences.
module tb_serial_word_adder;

    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_word_adder_if #(.CNT_W(CNT_W)) bus_if ();

    serial_word_adder #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        first;
        logic        last;
        logic [31:0] e_sum;
        logic [2:0]  e_idx;
        logic        e_last;
        logic        e_cout;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic cin, logic first,
                                logic last, logic [31:0] s, logic [2:0] idx, logic el,
                                logic ec, logic eo, logic ee);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.first = first; v.last = last;
        v.e_sum = s; v.e_idx = idx; v.e_last = el; v.e_cout = ec; v.e_ovf = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic first, input logic last);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_cin   = cin;
        bus_if.in_first = first;
        bus_if.in_last  = last;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_sum"},   bus_if.out_sum,         32'd0);
        chk({tag, "_idx"},   32'(bus_if.out_idx),   32'd0);
        chk({tag, "_last"},  32'(bus_if.out_last),  32'd0);
        chk({tag, "_cout"},  32'(bus_if.out_cout),  32'd0);
        chk({tag, "_ovf"},   32'(bus_if.out_ovf),   32'd0);
        chk({tag, "_err"},   32'(bus_if.seq_err),   32'd0);
        chk({tag, "_ready"}, 32'(bus_if.in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.in_cin    = 1'b0;
        bus_if.in_first  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;

        // Single-word, carry chain, final carry/overflow, protocol errors, length overflow
        vecs.push_back(mk(32'h0000000A, 32'h00000005, 0, 1, 1, 32'h0000000F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 0, 1, 0, 32'h00000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 0, 0, 1, 32'h00000001, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
        vecs.push_back(mk(32'h7FFFFFFF, 32'h00000001, 0, 1, 1, 32'h80000000, 0, 1, 0, 1, 0));
        vecs.push_back(mk(32'h00000001, 32'h00000002, 0, 1, 0, 32'h00000003, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000010, 32'h00000020, 0, 1, 0, 32'h00000030, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000005, 32'h00000006, 1, 0, 1, 32'h0000000B, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h00000100, 32'h00000001, 1, 0, 1, 32'h00000102, 0, 1, 0, 0, 1));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 32'h00000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 0, 0, 0, 32'h00000001, 1, 0, 0, 0, 0));
        for (int k = 2; k < 7; k++)
            vecs.push_back(mk(32'h0, 32'h0, 0, 0, 0, 32'h0, 3'(k), 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 0, 0, 0, 32'h00000000, 7, 1, 0, 0, 1));
        vecs.push_back(mk(32'h00000001, 32'h00000001, 0, 0, 1, 32'h00000002, 0, 1, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].first, vecs[i].last);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(bus_if.out_valid), 32'd1);
            chk($sformatf("v%0d_sum", i),   bus_if.out_sum,         vecs[i].e_sum);
            chk($sformatf("v%0d_idx", i),   32'(bus_if.out_idx),   32'(vecs[i].e_idx));
            chk($sformatf("v%0d_last", i),  32'(bus_if.out_last),  32'(vecs[i].e_last));
            chk($sformatf("v%0d_cout", i),  32'(bus_if.out_cout),  32'(vecs[i].e_cout));
            chk($sformatf("v%0d_ovf", i),   32'(bus_if.out_ovf),   32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_err", i),   32'(bus_if.seq_err),   32'(vecs[i].e_err));
        end
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(bus_if.out_valid), 32'd0);
        chk("drain_err",   32'(bus_if.seq_err),   32'd0);

        // Backpressure: 4-word stream, out_ready low for three cycles
        fork
            begin : driver
                for (int k = 0; k < 4; k++) begin
                    int n;
                    drive(32'hAAAAAAAA, 32'h55555555, 1'b1, k == 0, k == 3);
                    n = 0;
                    @(negedge clk);
                    while (!bus_if.in_ready && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 20) chk("bp_accept_timeout", 32'd1, 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus_if.in_valid = 1'b0;
            end
            begin : monitor
                int got;
                logic stalled;
                logic [2:0] held_idx;
                got = 0;
                stalled = 1'b0;
                held_idx = '0;
                for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                    @(posedge clk);
                    #1;
                    bus_if.out_ready = !(cyc >= 2 && cyc < 5);
                    @(negedge clk);
                    if (stalled && bus_if.out_valid)
                        chk("bp_hold_idx", 32'(bus_if.out_idx), 32'(held_idx));
                    if (bus_if.out_valid && !bus_if.out_ready) begin
                        chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
                        stalled  = 1'b1;
                        held_idx = bus_if.out_idx;
                    end else begin
                        stalled = 1'b0;
                    end
                    if (bus_if.out_valid && bus_if.out_ready) begin
                        chk($sformatf("bp%0d_sum", got),  bus_if.out_sum,        32'h00000000);
                        chk($sformatf("bp%0d_idx", got),  32'(bus_if.out_idx),  32'(got));
                        chk($sformatf("bp%0d_last", got), 32'(bus_if.out_last), 32'(got == 3));
                        chk($sformatf("bp%0d_cout", got), 32'(bus_if.out_cout), 32'(got == 3));
                        chk($sformatf("bp%0d_ovf", got),  32'(bus_if.out_ovf),  32'd0);
                        got++;
                    end
                end
                chk("bp_word_count", 32'(got), 32'd4);
            end
        join
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_no_dup", 32'(bus_if.out_valid), 32'd0);

        // Reset during word 2 of a 4-word operation
        drive(32'h11111111, 32'h22222222, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b0;
        drive(32'h12345678, 32'h87654321, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("post_sum",  bus_if.out_sum,         32'h9999999A);
        chk("post_idx",  32'(bus_if.out_idx),   32'd0);
        chk("post_last", 32'(bus_if.out_last),  32'd1);
        chk("post_cout", 32'(bus_if.out_cout),  32'd0);
        chk("post_err",  32'(bus_if.seq_err),   32'd0);
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_adder.md
Name: serial_word_adder

Overview:
- Multi-word (multi-precision) adder front-end that drives the team's 32-bit ripple_carry_adder.
- Accepts a stream of 32-bit operand word pairs, least-significant word first, over a valid/ready handshake.
- Chains the adder's carry-out into the next word's carry-in through a register.
- Emits registered sum words downstream with final carry and signed-overflow flags, so operands up to 2^CNT_W words wide can be added using one 32-bit adder.

Parameters:
- CNT_W, 3, width of the word-index counter; max operation length is 2^CNT_W words (default 8 words = 256 bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  block can accept a word this cycle.
- in_a  in  32  operand A word.
- in_b  in  32  operand B word.
- in_cin  in  1  carry-in; used only on a word with in_first=1.
- in_first  in  1  word is least-significant word of a new operation.
- in_last  in  1  word is most-significant word of the operation.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result word.
- out_sum  out  32  sum word.
- out_idx  out  CNT_W  index of this word within its operation (0 = LS word).
- out_last  out  1  result word is the MS word.
- out_cout  out  1  final carry-out; meaningful only when out_last=1, else 0.
- out_ovf  out  1  signed overflow of the full-width add; meaningful only when out_last=1, else 0.
- seq_err  out  1  one-cycle pulse on a protocol error (see Behaviour).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs and internal registers go to 0: out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, seq_err, carry register, word counter.
  - State goes to IDLE.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards the partial operation and any pending output word.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - A word is accepted when in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
- Latency: one cycle, accept edge to out_valid=1. Full throughput of 1 word/cycle when out_ready is held at 1.
- Datapath per accepted word:
  - cin_eff = in_first ? in_cin : carry_q.
  - ripple_carry_adder(a=in_a, b=in_b, cin=cin_eff) produces sum and cout.
  - carry_q <= cout.
  - out_sum <= sum.
  - out_idx <= word counter.
- State machine (IDLE, ACTIVE):
  - IDLE, accepted word with in_first=1: counter<=1; state->ACTIVE, or stays IDLE if in_last=1 (single-word operation).
  - IDLE, accepted word with in_first=0: protocol error. seq_err pulses; word is processed as first word with cin_eff=in_cin; idx=0.
  - ACTIVE, accepted word with in_first=0: counter++; in_last=1 returns state to IDLE.
  - ACTIVE, accepted word with in_first=1: protocol error. seq_err pulses; old operation is abandoned; word starts a new operation at idx=0.
  - ACTIVE, counter at 2^CNT_W-1 and in_last=0: word is processed, out_last is forced to 1, seq_err pulses, state->IDLE (length overflow).
- Last-word flags, registered with the last word:
  - out_last <= 1.
  - out_cout <= cout.
  - out_ovf <= (in_a[31]==in_b[31]) && (sum[31]!=in_a[31]).
- Simultaneous events: output drain and new accept in the same cycle is legal; the output register is reloaded.
- No wrap of out_sum: each word is exact modulo 2^32; carry is propagated only through carry_q.

Decomposition:
- Shared package holds:
  - WORD_W=32 constant.
  - State enum (IDLE, ACTIVE).
- Sub-module: the existing ripple_carry_adder, instantiated once, purely combinational.
- Control and registers stay in serial_word_adder.

Test Plan:
- Single word: a=0000000A, b=00000005, cin=0, first=last=1 -> next cycle out_sum=0000000F, idx=0, last=1, cout=0, ovf=0.
- Two-word 64-bit add with carry chain:
  - Stimulus: {a=FFFFFFFF,b=00000001,first} then {a=00000000,b=00000000,last}.
  - Response: sums 00000000 (idx0) and 00000001 (idx1, last); cout=0.
- Final carry and overflow:
  - Single word a=FFFFFFFF, b=FFFFFFFF, cin=1 -> sum=FFFFFFFF, cout=1, ovf=0.
  - Single word a=7FFFFFFF, b=00000001 -> sum=80000000, ovf=1.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles during a 4-word stream.
  - Response: in_ready=0 while out_valid && !out_ready; out_sum stable; no word lost or duplicated; carries still correct (a=AAAAAAAA, b=55555555, cin=1 on each word -> sums 00000000, carries 1).
- Protocol errors:
  - in_first=1 mid-operation -> seq_err one cycle, idx restarts at 0.
  - in_first=0 in IDLE -> seq_err, idx=0.
- Reset mid-op: rst during word 2 of 4 -> all outputs 0 next cycle; a subsequent fresh single-word op (12345678+87654321, cin=1) gives 9999999A, cout=0.
